// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART APB register front-end: register offsets,
// CTRL/STATUS bit positions and the transfer FSM states.
package uart_apb_pkg;

  localparam logic [2:0] OFF_TXDATA  = 3'd0;
  localparam logic [2:0] OFF_RXDATA  = 3'd1;
  localparam logic [2:0] OFF_STATUS  = 3'd2;
  localparam logic [2:0] OFF_CTRL    = 3'd3;
  localparam logic [2:0] OFF_BAUDDIV = 3'd4;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_RXIE = 1;
  localparam int CTRL_TXIE = 2;
  localparam int CTRL_SRST = 3;

  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_FULL  = 2;
  localparam int ST_TX_EMPTY = 3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

endpackage

// File: rtl/uart_apb_regif.sv
// APB3 slave register map for the UART core: TX/RX data, status, control and
// baud divisor, with bounded wait states on blocked FIFO accesses.
module uart_apb_regif
  import uart_apb_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                ADDR_W       = 12,
  parameter int                DIV_W        = 16,
  parameter logic [DIV_W-1:0]  BAUD_DIV_RST = DIV_W'(325),
  parameter int                MAX_WAIT     = 15
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PSELx,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [DATA_W-1:0] rx_fifo_dataOut,
  input  logic              rx_fifo_Empty,
  input  logic              rx_fifo_Full,
  input  logic              tx_fifo_Full,
  input  logic              tx_fifo_Empty,
  output logic              rx_fifo_readEn,
  output logic              tx_fifo_writeEn,
  output logic [DATA_W-1:0] tx_fifo_dataIn,
  output logic              uart_en,
  output logic [DIV_W-1:0]  baud_div,
  output logic              soft_reset,
  output logic              irq
);

  localparam int WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  state_t            state, state_nx;
  logic [WCW-1:0]    wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [31:0]       wdata_q;
  logic              rx_ie, tx_ie;

  // Decode from the live bus while idle, from the latched copy once stalled.
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_wr;
  logic [31:0]       cur_wdata;
  assign cur_addr  = (state == IDLE) ? PADDR  : addr_q;
  assign cur_wr    = (state == IDLE) ? PWRITE : wr_q;
  assign cur_wdata = (state == IDLE) ? PWDATA : wdata_q;

  logic [2:0] idx;
  logic       hi_ok, is_tx, is_rx, is_st, is_ctrl, is_baud, dec_err, blocked;
  assign idx     = cur_addr[4:2];
  assign hi_ok   = (cur_addr[ADDR_W-1:5] == '0);
  assign is_tx   = hi_ok && (idx == OFF_TXDATA);
  assign is_rx   = hi_ok && (idx == OFF_RXDATA);
  assign is_st   = hi_ok && (idx == OFF_STATUS);
  assign is_ctrl = hi_ok && (idx == OFF_CTRL);
  assign is_baud = hi_ok && (idx == OFF_BAUDDIV);
  assign dec_err = !(is_tx || is_rx || is_st || is_ctrl || is_baud)
                 || (is_tx && !cur_wr) || ((is_rx || is_st) && cur_wr);
  assign blocked = (is_tx && cur_wr && tx_fifo_Full) || (is_rx && !cur_wr && rx_fifo_Empty);

  logic unused_ok;
  assign unused_ok = ^{PADDR[1:0], addr_q[1:0], PWDATA, wdata_q};

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (PSELx && PENABLE) state_nx = blocked ? WAIT : RESP;
      WAIT: begin
        if (!PSELx)
          state_nx = IDLE;
        else if (!blocked || (MAX_WAIT != 0 && wait_cnt == WCW'(MAX_WAIT)))
          state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Values loaded into the registered outputs on the RESP-entry edge.
  logic              to_resp, resp_err, resp_ok, wen_d, ren_d, srst_d;
  logic [31:0]       rdata;
  always_comb begin
    to_resp  = (state_nx == RESP);
    resp_err = dec_err || blocked;
    resp_ok  = to_resp && !resp_err;
    wen_d    = resp_ok && is_tx && cur_wr;
    ren_d    = resp_ok && is_rx && !cur_wr;
    srst_d   = resp_ok && is_ctrl && cur_wr && cur_wdata[CTRL_SRST];
    rdata    = '0;
    if (is_rx) rdata[DATA_W-1:0] = rx_fifo_dataOut;
    if (is_st) begin
      rdata[ST_RX_EMPTY] = rx_fifo_Empty;
      rdata[ST_RX_FULL]  = rx_fifo_Full;
      rdata[ST_TX_FULL]  = tx_fifo_Full;
      rdata[ST_TX_EMPTY] = tx_fifo_Empty;
    end
    if (is_ctrl) begin
      rdata[CTRL_EN]   = uart_en;
      rdata[CTRL_RXIE] = rx_ie;
      rdata[CTRL_TXIE] = tx_ie;
    end
    if (is_baud) rdata[DIV_W-1:0] = baud_div;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_q          <= '0;
      wr_q            <= 1'b0;
      wdata_q         <= '0;
      wait_cnt        <= '0;
      PRDATA          <= '0;
      PREADY          <= 1'b0;
      PSLVERR         <= 1'b0;
      rx_fifo_readEn  <= 1'b0;
      tx_fifo_writeEn <= 1'b0;
      tx_fifo_dataIn  <= '0;
      uart_en         <= 1'b0;
      rx_ie           <= 1'b0;
      tx_ie           <= 1'b0;
      baud_div        <= BAUD_DIV_RST;
      soft_reset      <= 1'b0;
      irq             <= 1'b0;
    end else begin
      if (state == IDLE && PSELx && PENABLE) begin
        addr_q  <= PADDR;
        wr_q    <= PWRITE;
        wdata_q <= PWDATA;
      end
      if (state_nx == WAIT) wait_cnt <= (state == IDLE) ? WCW'(1) : wait_cnt + WCW'(1);
      else                  wait_cnt <= '0;
      PREADY          <= to_resp;
      PSLVERR         <= to_resp && resp_err;
      tx_fifo_writeEn <= wen_d;
      rx_fifo_readEn  <= ren_d;
      soft_reset      <= srst_d;
      if (wen_d) tx_fifo_dataIn <= cur_wdata[DATA_W-1:0];
      if (to_resp && !cur_wr) PRDATA <= resp_err ? '0 : rdata;
      if (resp_ok && cur_wr && is_ctrl) begin
        uart_en <= cur_wdata[CTRL_EN];
        rx_ie   <= cur_wdata[CTRL_RXIE];
        tx_ie   <= cur_wdata[CTRL_TXIE];
      end
      if (resp_ok && cur_wr && is_baud) baud_div <= cur_wdata[DIV_W-1:0];
      irq <= (rx_ie && !rx_fifo_Empty) || (tx_ie && tx_fifo_Empty);
    end
  end

endmodule

// File: tb/tb_uart_apb_regif.sv
// Directed bench for uart_apb_regif: register map, wait states, timeout,
// error responses, interrupt and asynchronous reset behaviour.
module tb_uart_apb_regif;

  logic        PCLK, PRESETn;
  logic [11:0] PADDR;
  logic        PSELx, PENABLE, PWRITE;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [7:0]  rx_fifo_dataOut, tx_fifo_dataIn;
  logic        rx_fifo_Empty, rx_fifo_Full, tx_fifo_Full, tx_fifo_Empty;
  logic        rx_fifo_readEn, tx_fifo_writeEn;
  logic        uart_en, soft_reset, irq;
  logic [15:0] baud_div;

  int npass = 0;
  int ntotal = 0;

  uart_apb_regif dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .rx_fifo_dataOut(rx_fifo_dataOut), .rx_fifo_Empty(rx_fifo_Empty), .rx_fifo_Full(rx_fifo_Full),
    .tx_fifo_Full(tx_fifo_Full), .tx_fifo_Empty(tx_fifo_Empty), .rx_fifo_readEn(rx_fifo_readEn),
    .tx_fifo_writeEn(tx_fifo_writeEn), .tx_fifo_dataIn(tx_fifo_dataIn), .uart_en(uart_en),
    .baud_div(baud_div), .soft_reset(soft_reset), .irq(irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One APB transfer; counts strobes seen in each access-phase cycle.
  task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                     input int maxc, output logic [31:0] rd, output logic err, output int cyc,
                     output int nwen, output int nren, output int nsrst, output logic [7:0] txd);
    rd = '0; err = 1'b0; cyc = 0; nwen = 0; nren = 0; nsrst = 0; txd = '0;
    @(posedge PCLK); #1;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    do begin
      @(posedge PCLK); #1;
      cyc++;
      nwen  += int'(tx_fifo_writeEn);
      nren  += int'(rx_fifo_readEn);
      nsrst += int'(soft_reset);
      if (tx_fifo_writeEn) txd = tx_fifo_dataIn;
    end while (!PREADY && cyc < maxc);
    rd = PRDATA; err = PSLVERR;
    if (!PREADY) cyc = -1;
    PSELx = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    chk("pready_one_cycle", {31'b0, PREADY}, 32'd0);
    chk("strobes_after", {29'b0, tx_fifo_writeEn, rx_fifo_readEn, soft_reset}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        err;
  int          cyc, nw, nr, ns;
  logic [7:0]  txd;

  initial begin
    PRESETn = 1'b0; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    rx_fifo_dataOut = '0; rx_fifo_Empty = 1'b1; rx_fifo_Full = 1'b0;
    tx_fifo_Full = 1'b0; tx_fifo_Empty = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_ready_err", {30'b0, PREADY, PSLVERR}, 32'd0);
    chk("rst_baud", {16'b0, baud_div}, 32'd325);
    chk("rst_ctl_outs", {28'b0, uart_en, irq, soft_reset, tx_fifo_writeEn | rx_fifo_readEn}, 32'd0);
    chk("rst_txdata", {24'b0, tx_fifo_dataIn}, 32'd0);
    @(negedge PCLK); PRESETn = 1'b1;

    apb(1'b0, 12'h010, 32'd0, 20, rd, err, cyc, nw, nr, ns, txd);
    chk("baud_rd", rd, 32'd325);
    chk("baud_err", {31'b0, err}, 32'd0);
    chk("baud_lat", cyc, 32'd1);
    apb(1'b0, 12'h00C, 32'd0, 20, rd, err, cyc, nw, nr, ns, txd);
    chk("ctrl_rst_rd", rd, 32'd0);

    apb(1'b1, 12'h000, 32'h1A5, 20, rd, err, cyc, nw, nr, ns, txd);
    chk("tx_lat", cyc, 32'd1);
    chk("tx_err", {31'b0, err}, 32'd0);
    chk("tx_nwen", nw, 32'd1);
    chk("tx_data", {24'b0, txd}, 32'hA5);

    // RX read stalls 4 access cycles on an empty FIFO
    rx_fifo_Empty = 1'b1;
    fork
      apb(1'b0, 12'h004, 32'd0, 40, rd, err, cyc, nw, nr, ns, txd);
      begin
        wait (PENABLE);
        repeat (4) @(posedge PCLK);
        #1 rx_fifo_Empty = 1'b0; rx_fifo_dataOut = 8'h3C;
      end
    join
    chk("rx_lat", cyc, 32'd5);
    chk("rx_data", rd, 32'h3C);
    chk("rx_nren", nr, 32'd1);
    chk("rx_err", {31'b0, err}, 32'd0);

    tx_fifo_Full = 1'b1;
    apb(1'b1, 12'h000, 32'h55, 40, rd, err, cyc, nw, nr, ns, txd);
    chk("tmo_lat", cyc, 32'd16);
    chk("tmo_err", {31'b0, err}, 32'd1);
    chk("tmo_nwen", nw, 32'd0);
    tx_fifo_Full = 1'b0;

    rx_fifo_Full = 1'b1;
    apb(1'b0, 12'h008, 32'd0, 20, rd, err, cyc, nw, nr, ns, txd);
    chk("status_rd", rd, 32'hA);
    rx_fifo_Full = 1'b0;

    apb(1'b1, 12'h00C, 32'hF, 20, rd, err, cyc, nw, nr, ns, txd);
    chk("ctrl_err", {31'b0, err}, 32'd0);
    chk("ctrl_srst", ns, 32'd1);
    chk("ctrl_en", {31'b0, uart_en}, 32'd1);
    chk("irq_rx", {31'b0, irq}, 32'd1);
    apb(1'b0, 12'h00C, 32'd0, 20, rd, err, cyc, nw, nr, ns, txd);
    chk("ctrl_rd", rd, 32'h7);
    apb(1'b0, 12'h020, 32'd0, 20, rd, err, cyc, nw, nr, ns, txd);
    chk("bad_rd_err", {31'b0, err}, 32'd1);
    chk("bad_rd_data", rd, 32'd0);

    rx_fifo_Empty = 1'b1; tx_fifo_Empty = 1'b0;
    @(posedge PCLK); #1;
    chk("irq_off", {31'b0, irq}, 32'd0);
    tx_fifo_Empty = 1'b1;
    @(posedge PCLK); #1;
    chk("irq_tx", {31'b0, irq}, 32'd1);

    apb(1'b0, 12'h000, 32'd0, 20, rd, err, cyc, nw, nr, ns, txd);
    chk("rd_tx_err", {31'b0, err}, 32'd1);
    chk("rd_tx_lat", cyc, 32'd1);
    apb(1'b1, 12'h008, 32'hF, 20, rd, err, cyc, nw, nr, ns, txd);
    chk("wr_st_err", {31'b0, err}, 32'd1);
    apb(1'b1, 12'h004, 32'h12, 20, rd, err, cyc, nw, nr, ns, txd);
    chk("wr_rx_err", {31'b0, err}, 32'd1);
    chk("wr_rx_strb", nw + nr, 32'd0);
    apb(1'b1, 12'h020, 32'hFFFF_FFFF, 20, rd, err, cyc, nw, nr, ns, txd);
    chk("wr_bad_err", {31'b0, err}, 32'd1);
    apb(1'b1, 12'h110, 32'h0000_0001, 20, rd, err, cyc, nw, nr, ns, txd);
    chk("wr_hi_err", {31'b0, err}, 32'd1);
    chk("baud_kept", {16'b0, baud_div}, 32'd325);
    apb(1'b0, 12'h00C, 32'd0, 20, rd, err, cyc, nw, nr, ns, txd);
    chk("ctrl_kept", rd, 32'h7);

    apb(1'b1, 12'h010, 32'h1234, 20, rd, err, cyc, nw, nr, ns, txd);
    chk("baud_out", {16'b0, baud_div}, 32'h1234);
    apb(1'b0, 12'h010, 32'd0, 20, rd, err, cyc, nw, nr, ns, txd);
    chk("baud_rdback", rd, 32'h1234);

    // PSELx dropped while stalled: transfer abandoned silently
    tx_fifo_Full = 1'b1;
    @(posedge PCLK); #1;
    PSELx = 1'b1; PWRITE = 1'b1; PADDR = 12'h000; PWDATA = 32'h66;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 PSELx = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    tx_fifo_Full = 1'b0;
    chk("abort_ready", {31'b0, PREADY}, 32'd0);
    repeat (2) @(posedge PCLK);
    #1;
    chk("abort_strb", {30'b0, PREADY, tx_fifo_writeEn}, 32'd0);

    // Async reset while stalled in WAIT
    tx_fifo_Full = 1'b1;
    @(posedge PCLK); #1;
    PSELx = 1'b1; PWRITE = 1'b1; PADDR = 12'h000; PWDATA = 32'h77;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b0;
    #1;
    chk("arst_ready", {30'b0, PREADY, PSLVERR}, 32'd0);
    chk("arst_strb", {30'b0, tx_fifo_writeEn, rx_fifo_readEn}, 32'd0);
    chk("arst_regs", {15'b0, uart_en, baud_div}, 32'd325);
    PSELx = 1'b0; PENABLE = 1'b0; tx_fifo_Full = 1'b0;
    @(negedge PCLK); PRESETn = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    chk("arst_no_push", {31'b0, tx_fifo_writeEn}, 32'd0);
    apb(1'b0, 12'h010, 32'd0, 20, rd, err, cyc, nw, nr, ns, txd);
    chk("arst_baud_rd", rd, 32'd325);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/uart_apb_regif.md
Name: uart_apb_regif

Overview:
Parametrised APB3 slave front-end for the UART core. It replaces the single-purpose FIFO strobe interface with a decoded register map: TX/RX data, status, control and baud divisor. It adds wait-state handling with a bounded timeout, PSLVERR error reporting and an interrupt output. It sits between the APB bus and the UART TX/RX FIFOs and baud generator.

Parameters:
DATA_W, 8, UART character width (5..9); width of the FIFO data ports.
ADDR_W, 12, PADDR width; only PADDR[4:2] is decoded, PADDR[ADDR_W-1:5] must be 0.
DIV_W, 16, baud divisor register width.
BAUD_DIV_RST, 16'd325, reset value of the baud divisor.
MAX_WAIT, 15, maximum wait cycles on a blocked FIFO access before an error response; 0 = wait indefinitely.

Ports:
PCLK  in  1  APB clock; all logic on its rising edge.
PRESETn  in  1  asynchronous active-low reset.
PADDR  in  ADDR_W  byte address.
PSELx  in  1  slave select.
PENABLE  in  1  access phase.
PWRITE  in  1  1 = write.
PWDATA  in  32  write data.
PRDATA  out  32  read data, valid when PREADY=1.
PREADY  out  1  transfer complete.
PSLVERR  out  1  error response, valid only with PREADY.
rx_fifo_dataOut  in  DATA_W  RX FIFO head (first-word-fall-through).
rx_fifo_Empty  in  1  RX FIFO empty.
rx_fifo_Full  in  1  RX FIFO full.
tx_fifo_Full  in  1  TX FIFO full.
tx_fifo_Empty  in  1  TX FIFO empty.
rx_fifo_readEn  out  1  one-cycle pop strobe.
tx_fifo_writeEn  out  1  one-cycle push strobe.
tx_fifo_dataIn  out  DATA_W  push data, valid with tx_fifo_writeEn.
uart_en  out  1  core enable (CTRL[0]).
baud_div  out  DIV_W  baud divisor.
soft_reset  out  1  one-cycle pulse; clears the UART core and FIFOs.
irq  out  1  level interrupt.

Behaviour:
- Register map (word offsets):
  - 0x00 TXDATA: WO; a read returns an error.
  - 0x04 RXDATA: RO; zero-extended; a write returns an error.
  - 0x08 STATUS: RO; bits [3:0] = {tx_fifo_Empty, tx_fifo_Full, rx_fifo_Full, rx_fifo_Empty}; a write returns an error.
  - 0x0C CTRL: RW; [0] uart_en, [1] rx_ie, [2] tx_ie, [3] soft_reset (write-1 pulse, reads 0).
  - 0x10 BAUDDIV: RW, DIV_W bits.
  - Any other offset: error, no side effect, PRDATA=0.
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, both strobes 0, tx_fifo_dataIn=0, uart_en=0, rx_ie=0, tx_ie=0, baud_div=BAUD_DIV_RST, soft_reset=0, state=IDLE, wait_cnt=0. All outputs are registered.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On PSELx&PENABLE, latch address, direction and PWDATA.
  - A TXDATA write with tx_fifo_Full=1, or an RXDATA read with rx_fifo_Empty=1, goes to WAIT with wait_cnt=1.
  - Otherwise go to RESP.
- WAIT:
  - Re-evaluate the blocking flag every cycle. When it clears, go to RESP with a normal response.
  - If MAX_WAIT!=0 and wait_cnt==MAX_WAIT, go to RESP with PSLVERR=1 and no FIFO strobe.
  - Otherwise increment wait_cnt.
  - If PSELx drops (protocol violation), return to IDLE with no strobe and no response.
- RESP:
  - PREADY=1 for exactly one cycle, then IDLE. Minimum latency is one wait state: PREADY rises in the second access-phase cycle.
  - On the RESP-entry edge, register writes update and PRDATA loads.
  - During RESP, tx_fifo_writeEn=1 (tx_fifo_dataIn = PWDATA[DATA_W-1:0]) for a TXDATA write, or rx_fifo_readEn=1 for an RXDATA read. PRDATA has already captured rx_fifo_dataOut.
  - No strobe is issued on an error response.
- PREADY, PSLVERR and strobes are 0 outside RESP. PRDATA holds its value until the next read response.
- soft_reset goes high for one cycle in RESP when the CTRL write has bit 3 set. CTRL fields are written with the same write.
- irq = (rx_ie & ~rx_fifo_Empty) | (tx_ie & tx_fifo_Empty), registered (one-cycle lag).
- Async reset asserted mid-transfer: everything returns to reset values immediately; no strobe completes.

Decomposition:
- Package uart_apb_pkg: register offset localparams, CTRL bit indices, STATUS bit indices, state enum (IDLE/WAIT/RESP).
- No sub-module; the wait counter and decode stay inline (about 200 lines).

Test Plan:
- Reset then read BAUDDIV -> PRDATA=325, PSLVERR=0, PREADY one cycle after PENABLE; CTRL reads 0.
- Write TXDATA 0x1A5 with tx_fifo_Full=0 -> one tx_fifo_writeEn pulse coincident with PREADY, tx_fifo_dataIn=0xA5 (DATA_W=8).
- Read RXDATA with rx_fifo_Empty=1 for 4 cycles, then the head becomes 0x3C -> PREADY on the cycle after Empty falls, PRDATA=0x3C, exactly one rx_fifo_readEn pulse.
- Write TXDATA with tx_fifo_Full held at 1 -> PREADY=1 and PSLVERR=1 at wait_cnt=15, no tx_fifo_writeEn.
- Write CTRL=0xF -> uart_en=1, irq=1 when rx not empty, single soft_reset pulse; CTRL reads back 0x7.
- Read TXDATA, write STATUS, access offset 0x20 -> PSLVERR=1 each time, no state change; PRESETn low during WAIT clears PREADY and strobes immediately.
